// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The state encodings are kept as plain constants so legacy code can still compare against them.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH  = 32;
  localparam int unsigned PC_INCREMENT = 4;
  localparam int unsigned LAT_WIDTH    = 4;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_WAIT  = WAIT,
    ST_HOLD  = HOLD,
    ST_FAULT = FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_latency_timer.sv
// Down-counter that tracks cycles remaining until memory data is valid.
module fetch_latency_timer
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = LAT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues fetches, waits MEM_LATENCY cycles, hands words to decode.
// Optional FETCH_ALIGN_CHECK_EN adds a misaligned-fetch fault output and FAULT state.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          MEM_LATENCY = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic [PC_WIDTH-1:0]    mem_address,
  output logic                   mem_read,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                   fault
`endif
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic                issue_req;
  logic                issue;
  logic                misaligned;
  logic                timer_zero;
  logic                timer_dec;

  // An issue is wanted from IDLE, or from HOLD once decode takes the held word.
  always_comb begin
    issue_req = 1'b0;
    if (enable) begin
      if (state == ST_IDLE) begin
        issue_req = 1'b1;
      end else if ((state == ST_HOLD) && instr_ready) begin
        issue_req = 1'b1;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issue     = issue_req && !misaligned && !redirect_valid;
  assign timer_dec = (state == ST_WAIT) && !redirect_valid;

  fetch_latency_timer #(
    .WIDTH (LAT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (issue),
    .load_value (LAT_WIDTH'(MEM_LATENCY - 1)),
    .decrement  (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      mem_read    <= 1'b0;
      mem_address <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else if (redirect_valid) begin
      state       <= ST_IDLE;
      pc          <= redirect_pc;
      mem_read    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_req) begin
            if (misaligned) begin
              state <= ST_FAULT;
`ifdef FETCH_ALIGN_CHECK_EN
              fault <= 1'b1;
`endif
            end else begin
              mem_address <= pc;
              mem_read    <= 1'b1;
              state       <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (timer_zero) begin
            instr_out   <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_WIDTH'(PC_INCREMENT);
            mem_read    <= 1'b0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (!enable) begin
              state <= ST_IDLE;
            end else if (misaligned) begin
              state <= ST_FAULT;
`ifdef FETCH_ALIGN_CHECK_EN
              fault <= 1'b1;
`endif
            end else begin
              mem_address <= pc;
              mem_read    <= 1'b1;
              state       <= ST_WAIT;
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random traffic vs a transaction model.
module tb_fetch_controller;

  localparam int unsigned PW  = 64;
  localparam int unsigned LAT = 2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, enable, instr_ready, redirect_valid;
  logic [PW-1:0] redirect_pc, mem_address, instr_pc;
  logic [31:0]   mem_data, instr_out;
  logic          mem_read, instr_valid;
  logic          fault_obs;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          fault;
  assign fault_obs = fault;
`else
  assign fault_obs = 1'b0;
`endif

  fetch_controller #(
    .PC_WIDTH    (PW),
    .MEM_LATENCY (LAT),
    .RESET_PC    (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_data       (mem_data),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fault          (fault)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B1F03E5;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  // Transaction-level reference: one outstanding fetch, one held word, a pc.
  logic [63:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_instr;
  logic        m_busy, m_valid, m_fault;
  int          m_left;
  bit          known = 1'b0;

  task automatic compare_all();
    if (known) begin
      check("mem_read",    64'(mem_read),    64'(m_busy));
      check("mem_address", mem_address,      m_addr);
      check("instr_valid", 64'(instr_valid), 64'(m_valid));
      check("instr_out",   64'(instr_out),   64'(m_instr));
      check("instr_pc",    instr_pc,         m_ipc);
      if (ALIGN) check("fault", 64'(fault_obs), 64'(m_fault));
    end
  endtask

  task automatic model_update(input bit rst, input bit en, input bit rdy, input bit rv,
                              input logic [63:0] rpc);
    bit can_issue;
    if (rst) begin
      m_pc = 64'h0; m_addr = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
      m_busy = 1'b0; m_valid = 1'b0; m_fault = 1'b0; m_left = 0;
      known = 1'b1;
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_busy = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (m_busy) begin
      if (m_left == 0) begin
        m_instr = mem_word(m_addr); m_ipc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_busy = 1'b0;
      end else begin
        m_left--;
      end
    end else begin
      can_issue = !m_valid || rdy;
      if (m_valid && rdy) m_valid = 1'b0;
      if (can_issue && en) begin
        if (ALIGN && (m_pc[1:0] != 2'b00)) begin
          m_fault = 1'b1;
        end else begin
          m_addr = m_pc; m_busy = 1'b1; m_left = LAT - 1;
        end
      end
    end
  endtask

  // One clock: check outputs, drive inputs, feed memory, advance model, cross the edge.
  task automatic step(input bit rst, input bit en, input bit rdy, input bit rv,
                      input logic [63:0] rpc);
    compare_all();
    reset = rst; enable = en; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (known && m_busy && (m_left == 0)) mem_data = mem_word(m_addr);
    else mem_data = $urandom;
    model_update(rst, en, rdy, rv, rpc);
    @(posedge clk);
    @(negedge clk);
  endtask

  int unsigned vidx[$];
  logic [63:0] vpc[$];
  logic [31:0] held_instr;
  logic [63:0] held_pc, rpc_r;
  bit          rst_r, rv_r;

  initial begin
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; mem_data = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_mem_address", mem_address, 64'h0);
    check("rst_instr_valid", 64'(instr_valid), 64'h0);

    // First fetch: valid exactly MEM_LATENCY+1 cycles after enable
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("lat_not_early", 64'(instr_valid), 64'h0);
    step(0, 1, 0, 0, 0);
    check("lat_valid", 64'(instr_valid), 64'h1);
    check("first_instr", 64'(instr_out), 64'h8B1F03E5);
    check("first_pc", instr_pc, 64'h0);

    // Back-to-back stream with ready held high
    for (int unsigned i = 0; i < 10; i++) begin
      if (instr_valid) begin vidx.push_back(i); vpc.push_back(instr_pc); end
      if (i < 9) step(0, 1, 1, 0, 0);
    end
    check("stream_count", 64'(vidx.size()), 64'd4);
    for (int unsigned k = 0; k < vidx.size(); k++) begin
      check("stream_pc", vpc[k], 64'(4 * k));
      check("stream_gap", 64'(vidx[k]), 64'(3 * k));
    end

    // Decode stalls: held outputs stable, nothing new issued
    held_instr = instr_out; held_pc = instr_pc;
    for (int unsigned i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      check("stall_valid", 64'(instr_valid), 64'h1);
      check("stall_instr", 64'(instr_out), 64'(held_instr));
      check("stall_pc", instr_pc, held_pc);
      check("stall_no_read", 64'(mem_read), 64'h0);
    end

    // Redirect while a fetch is outstanding
    step(0, 1, 1, 0, 0);
    check("wait_read", 64'(mem_read), 64'h1);
    step(0, 1, 0, 1, 64'h40);
    check("redir_drop_read", 64'(mem_read), 64'h0);
    check("redir_no_valid", 64'(instr_valid), 64'h0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("redir_pc", instr_pc, 64'h40);

    // Redirect landing on the wait counter's last cycle
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 64'h80);
    check("late_redir_valid", 64'(instr_valid), 64'h0);

    // PC wrap at the top of the address space
    step(0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check("wrap_top_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    check("wrap_zero_pc", instr_pc, 64'h0);
    check("wrap_valid", 64'(instr_valid), 64'h1);

`ifdef FETCH_ALIGN_CHECK_EN
    step(0, 0, 1, 1, 64'h42);
    step(0, 1, 0, 0, 0);
    check("align_fault", 64'(fault), 64'h1);
    check("align_no_read", 64'(mem_read), 64'h0);
    step(0, 1, 0, 0, 0);
    check("align_fault_held", 64'(fault), 64'h1);
    step(0, 1, 0, 1, 64'h44);
    check("align_cleared", 64'(fault), 64'h0);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check("align_resume_pc", instr_pc, 64'h44);
`endif

    // Random traffic including mid-fetch resets and redirects
    for (int unsigned i = 0; i < 4000; i++) begin
      rst_r = ($urandom_range(199) == 0);
      rv_r  = ($urandom_range(24) == 0);
      rpc_r = {$urandom, $urandom};
      if ($urandom_range(3) == 0) rpc_r = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      if ($urandom_range(3) != 0) rpc_r[1:0] = 2'b00;
      step(rst_r, $urandom_range(3) != 0, $urandom_range(1) == 1, rv_r, rpc_r);
    end
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 64, instruction address width.
REQ-002 SHALL have parameter MEM_LATENCY, default 2, cycles from address issue to valid memory data; legal range 1..15.
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new fetches to be issued.
REQ-007 SHALL have port mem_address  output  PC_WIDTH  byte address to instruction memory.
REQ-008 SHALL have port mem_read  output  1  high while a fetch is outstanding.
REQ-009 SHALL have port mem_data  input  32  little-endian instruction word from memory.
REQ-010 SHALL have port instr_out  output  32  captured instruction.
REQ-011 SHALL have port instr_pc  output  PC_WIDTH  address of instr_out.
REQ-012 SHALL have port instr_valid / instr_ready  output / input  1 each  valid-ready handshake to decode.
REQ-013 SHALL have port redirect_valid / redirect_pc  input  1 / PC_WIDTH  branch redirect request and target.

Function
REQ-014 SHALL implement states IDLE, WAIT and HOLD.
REQ-015 IDLE with enable=1 SHALL drive mem_address=pc and mem_read=1, load the latency counter with MEM_LATENCY-1, and go to WAIT.
REQ-016 WAIT SHALL hold mem_address stable and decrement the counter each cycle.
REQ-017 WAIT at counter 0 SHALL capture mem_data into instr_out, set instr_pc=pc and instr_valid=1, advance pc by 4 modulo 2^PC_WIDTH, drop mem_read, and go to HOLD.
REQ-018 HOLD SHALL keep instr_out, instr_pc and instr_valid stable until instr_ready=1.
REQ-019 HOLD with instr_ready=1 and enable=1 SHALL issue the next fetch in the same cycle and go to WAIT, giving back-to-back throughput of one instruction per MEM_LATENCY+1 cycles.
REQ-020 HOLD with instr_ready=1 and enable=0 SHALL clear instr_valid and go to IDLE.
REQ-021 Latency from enable rising in IDLE to instr_valid=1 SHALL be exactly MEM_LATENCY+1 cycles.
REQ-022 enable=0 during WAIT SHALL NOT abort the outstanding fetch; it SHALL only suppress the next issue.
REQ-023 redirect_valid=1 SHALL have priority in every state: pc<=redirect_pc, instr_valid<=0, any outstanding fetch discarded (mem_read<=0), next state IDLE.
REQ-024 redirect_valid coinciding with instr_ready=1 SHALL cause the held instruction to count as consumed, with no further effect beyond the redirect.
REQ-025 redirect_valid coinciding with WAIT counter 0 SHALL discard the returning mem_data.

Reset
REQ-026 reset=1 SHALL set state=IDLE, pc=RESET_PC, counter=0, mem_read=0, mem_address=RESET_PC, instr_valid=0, instr_out=0 and instr_pc=0.
REQ-027 reset SHALL take priority over redirect_valid and abandon any outstanding fetch mid-operation.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN, when defined, SHALL add output fault (1 bit, reset 0) and an extra state FAULT.
REQ-029 With FETCH_ALIGN_CHECK_EN, a fetch issue with pc[1:0]!=0 SHALL instead set fault=1 and enter FAULT, which is left only by reset or redirect.
REQ-030 Without FETCH_ALIGN_CHECK_EN, there SHALL be no fault port, and pc[1:0] SHALL be ignored (address issued as-is).

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum typedef, INSTR_WIDTH=32 and the PC increment constant 4.
REQ-032 Sub-module fetch_latency_timer (load, decrement, zero flag) SHALL implement the latency counter.

Verification
REQ-033 Bench SHALL cover: reset, then enable=1 with MEM_LATENCY=2 and memory word 0x8B1F03E5 at address 0 -> instr_valid on cycle 3, instr_out=0x8B1F03E5, instr_pc=0.
REQ-034 Bench SHALL cover: instr_ready held at 1 for 4 instructions -> instr_pc sequence 0,4,8,12 with one valid every 3 cycles.
REQ-035 Bench SHALL cover: instr_ready=0 for 5 cycles in HOLD -> outputs stable, no new mem_read.
REQ-036 Bench SHALL cover: redirect_pc=0x40 mid-WAIT -> returning data discarded, next instr_pc=0x40.
REQ-037 Bench SHALL cover: redirect_pc=0xFFFFFFFFFFFFFFFC -> following instr_pc wraps to 0.
REQ-038 Bench SHALL cover, with FETCH_ALIGN_CHECK_EN: redirect_pc=0x42 -> fault=1 with no mem_read; redirect to 0x44 clears fault and fetch resumes.
